// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: default bit timing, 8N1 frame constants and the
// receive FSM state encodings. The transmit side imports the same package.
package uart_rx_pkg;

    localparam int DEF_CLK_HZ  = 50_000_000;
    localparam int DEF_BAUD    = 115_200;
    localparam int DEF_BIT_DIV = DEF_CLK_HZ / DEF_BAUD;

    // 8N1 framing
    localparam int   DATA_BITS = 8;
    localparam logic START_LVL = 1'b0;
    localparam logic STOP_LVL  = 1'b1;
    localparam logic IDLE_LVL  = 1'b1;

    // Bit timer counter is wide enough for BIT_DIV up to 511
    localparam int TIMER_W = 9;
    typedef logic [TIMER_W-1:0] timer_cnt_t;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_START     = 3'd1;
    localparam logic [2:0] ST_DATA      = 3'd2;
    localparam logic [2:0] ST_STOP      = 3'd3;
    localparam logic [2:0] ST_WAIT_HIGH = 3'd4;

    function automatic int half_div(input int div);
        return div / 2;
    endfunction

endpackage

// File: rtl/rs232_rx.sv
// RS232 receive core: rx synchronizer, 8N1 FSM, shift register and the
// FIFO write interface. Bit timing comes from rx_bit_timer via tick.
module rs232_rx
    import uart_rx_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    input  logic       full,
    input  logic       tick,
    output logic       timer_clr,
    output logic       timer_en,
    output logic       wr_en,
    output logic [7:0] dout,
    output logic       frame_err,
    output logic       overrun,
    output logic [2:0] state_dbg
);

    logic       rx_meta;
    logic       rx_s;
    logic       rx_prev;
    logic [2:0] state;
    logic [2:0] bit_cnt;
    logic [7:0] shreg;
    logic       start_det;

    // Edge is detected in IDLE from a registered copy of rx_s, so a start
    // edge on the very cycle the FSM re-enters IDLE is not lost.
    assign start_det = (state == ST_IDLE) && rx_prev && !rx_s;
    assign timer_clr = start_det;
    assign timer_en  = (state == ST_START) || (state == ST_DATA) || (state == ST_STOP);
    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta   <= IDLE_LVL;
            rx_s      <= IDLE_LVL;
            rx_prev   <= IDLE_LVL;
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            shreg     <= '0;
            dout      <= '0;
            wr_en     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            rx_meta   <= rx;
            rx_s      <= rx_meta;
            rx_prev   <= rx_s;
            wr_en     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_det) begin
                        state   <= ST_START;
                        bit_cnt <= '0;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        if (rx_s == START_LVL) begin
                            state   <= ST_DATA;
                            bit_cnt <= '0;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        shreg   <= {rx_s, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'(DATA_BITS - 1)) begin
                            state <= ST_STOP;
                        end
                    end
                end
                ST_STOP: begin
                    // full is only consulted here, on the stop-sample cycle
                    if (tick) begin
                        if (rx_s == STOP_LVL) begin
                            state <= ST_IDLE;
                            if (full) begin
                                overrun <= 1'b1;
                            end else begin
                                wr_en <= 1'b1;
                                dout  <= shreg;
                            end
                        end else begin
                            frame_err <= 1'b1;
                            state     <= ST_WAIT_HIGH;
                        end
                    end
                end
                ST_WAIT_HIGH: begin
                    if (rx_s == IDLE_LVL) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/rx_bit_timer.sv
// Bit-period timer: cleared on start detect, ticks once at mid start bit and
// then once per bit period while enabled.
module rx_bit_timer
    import uart_rx_pkg::*;
#(
    parameter int BIT_DIV = DEF_BIT_DIV
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam timer_cnt_t HALF_LAST = timer_cnt_t'(half_div(BIT_DIV) - 1);
    localparam timer_cnt_t FULL_LAST = timer_cnt_t'(BIT_DIV - 1);

    timer_cnt_t cnt;
    logic       half;

    // The first tick after a clear lands half a bit in, i.e. mid start bit
    assign tick = en && !clr && (cnt == (half ? HALF_LAST : FULL_LAST));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt  <= '0;
            half <= 1'b1;
        end else if (clr) begin
            cnt  <= '0;
            half <= 1'b1;
        end else if (en) begin
            if (tick) begin
                cnt  <= '0;
                half <= 1'b0;
            end else begin
                cnt <= cnt + timer_cnt_t'(1);
            end
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver top: 8N1 bytes from rx are written into an external FIFO,
// with one-cycle frame error and overrun pulses.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int CLK_HZ  = DEF_CLK_HZ,
    parameter int BAUD    = DEF_BAUD,
    parameter int BIT_DIV = CLK_HZ / BAUD
) (
    input  logic       clk_50mhz,
    input  logic       rst_n,
    input  logic       rx,
    output logic       wr_clk,
    output logic       wr_en,
    output logic [7:0] dout,
    input  logic       full,
    output logic       frame_err,
    output logic       overrun,
    output logic [2:0] state_dbg
);

    logic tick;
    logic timer_clr;
    logic timer_en;

    // The FIFO write side runs on the same clock as the receiver
    assign wr_clk = clk_50mhz;

    rs232_rx u_rs232_rx (
        .clk       (clk_50mhz),
        .rst_n     (rst_n),
        .rx        (rx),
        .full      (full),
        .tick      (tick),
        .timer_clr (timer_clr),
        .timer_en  (timer_en),
        .wr_en     (wr_en),
        .dout      (dout),
        .frame_err (frame_err),
        .overrun   (overrun),
        .state_dbg (state_dbg)
    );

    rx_bit_timer #(
        .BIT_DIV (BIT_DIV)
    ) u_rx_bit_timer (
        .clk   (clk_50mhz),
        .rst_n (rst_n),
        .clr   (timer_clr),
        .en    (timer_en),
        .tick  (tick)
    );

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx at 434 clocks per bit.
module tb_uart_rx;

    localparam int         BIT    = 434;
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_WAIT = 3'd4;

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic       full;
    logic       wr_clk;
    logic       wr_en;
    logic [7:0] dout;
    logic       frame_err;
    logic       overrun;
    logic [2:0] state_dbg;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];

    uart_rx dut (
        .clk_50mhz (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .wr_clk    (wr_clk),
        .wr_en     (wr_en),
        .dout      (dout),
        .full      (full),
        .frame_err (frame_err),
        .overrun   (overrun),
        .state_dbg (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #10 clk = ~clk;

    // output monitor, sampled away from the active edge
    always @(negedge clk) begin
        if (wr_en) begin
            wr_cnt++;
            got_q.push_back(dout);
        end
        if (frame_err) fe_cnt++;
        if (overrun) ov_cnt++;
    end

    // driver tasks
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop_lvl,
                              input logic full_data, input logic full_stop);
        full = full_data;
        rx   = 1'b0;
        idle(BIT);
        for (int i = 0; i < 8; i++) begin
            rx = data[i];
            idle(BIT);
        end
        full = full_stop;
        rx   = stop_lvl;
        idle(BIT);
        full = 1'b0;
    endtask

    // tests
    task automatic test_reset;
        rst_n = 1'b0;
        rx    = 1'b1;
        full  = 1'b0;
        idle(5);
        rst_n = 1'b1;
        idle(2);
        checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en got %b want 0", wr_en); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got %b want 0", frame_err); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b want 0", overrun); end
        checks++; if (dout !== 8'h00) begin errors++; $display("FAIL reset_dout got %h want 00", dout); end
        checks++; if (state_dbg !== S_IDLE) begin errors++; $display("FAIL reset_state got %0d want %0d", state_dbg, S_IDLE); end
    endtask

    task automatic test_basic;
        int wr0;
        logic [7:0] got;
        wr0 = wr_cnt;
        got_q.delete();
        exp_q.push_back(8'h55);
        send_frame(8'h55, 1'b1, 1'b0, 1'b0);
        idle(50);
        checks++; if (wr_cnt - wr0 !== 1) begin errors++; $display("FAIL basic_wr_count got %0d want 1", wr_cnt - wr0); end
        checks++; if (dout !== 8'h55) begin errors++; $display("FAIL basic_dout got %h want 55", dout); end
        got = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
        checks++; if (got !== exp_q.pop_front()) begin errors++; $display("FAIL basic_written_byte got %h want 55", got); end
    endtask

    task automatic test_glitch;
        int wr0, fe0;
        wr0 = wr_cnt;
        fe0 = fe_cnt;
        rx = 1'b0;
        idle(100);
        rx = 1'b1;
        idle(BIT * 2);
        checks++; if (wr_cnt - wr0 !== 0) begin errors++; $display("FAIL glitch_wr_count got %0d want 0", wr_cnt - wr0); end
        checks++; if (fe_cnt - fe0 !== 0) begin errors++; $display("FAIL glitch_frame_err got %0d want 0", fe_cnt - fe0); end
        checks++; if (state_dbg !== S_IDLE) begin errors++; $display("FAIL glitch_state got %0d want %0d", state_dbg, S_IDLE); end
    endtask

    task automatic test_frame_err;
        int wr0, fe0;
        wr0 = wr_cnt;
        fe0 = fe_cnt;
        send_frame(8'hA3, 1'b0, 1'b0, 1'b0);
        idle(2000);
        checks++; if (fe_cnt - fe0 !== 1) begin errors++; $display("FAIL ferr_pulses got %0d want 1", fe_cnt - fe0); end
        checks++; if (wr_cnt - wr0 !== 0) begin errors++; $display("FAIL ferr_wr_count got %0d want 0", wr_cnt - wr0); end
        checks++; if (state_dbg !== S_WAIT) begin errors++; $display("FAIL ferr_wait_state got %0d want %0d", state_dbg, S_WAIT); end
        rx = 1'b1;
        idle(BIT);
        send_frame(8'h3C, 1'b1, 1'b0, 1'b0);
        idle(50);
        checks++; if (wr_cnt - wr0 !== 1) begin errors++; $display("FAIL ferr_recover_wr got %0d want 1", wr_cnt - wr0); end
        checks++; if (dout !== 8'h3C) begin errors++; $display("FAIL ferr_recover_dout got %h want 3c", dout); end
    endtask

    task automatic test_overrun;
        int wr0, ov0;
        wr0 = wr_cnt;
        ov0 = ov_cnt;
        send_frame(8'hA3, 1'b1, 1'b1, 1'b1);
        idle(50);
        checks++; if (ov_cnt - ov0 !== 1) begin errors++; $display("FAIL overrun_pulses got %0d want 1", ov_cnt - ov0); end
        checks++; if (wr_cnt - wr0 !== 0) begin errors++; $display("FAIL overrun_wr_count got %0d want 0", wr_cnt - wr0); end
        checks++; if (dout !== 8'h3C) begin errors++; $display("FAIL overrun_dout got %h want 3c", dout); end
    endtask

    task automatic test_full_ignored;
        int wr0, ov0;
        wr0 = wr_cnt;
        ov0 = ov_cnt;
        send_frame(8'h96, 1'b1, 1'b1, 1'b0);
        idle(50);
        checks++; if (wr_cnt - wr0 !== 1) begin errors++; $display("FAIL full_early_wr got %0d want 1", wr_cnt - wr0); end
        checks++; if (ov_cnt - ov0 !== 0) begin errors++; $display("FAIL full_early_overrun got %0d want 0", ov_cnt - ov0); end
        checks++; if (dout !== 8'h96) begin errors++; $display("FAIL full_early_dout got %h want 96", dout); end
    endtask

    task automatic test_back_to_back;
        int wr0;
        logic [7:0] got, want;
        wr0 = wr_cnt;
        got_q.delete();
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        send_frame(8'h00, 1'b1, 1'b0, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0, 1'b0);
        idle(50);
        checks++; if (wr_cnt - wr0 !== 2) begin errors++; $display("FAIL b2b_wr_count got %0d want 2", wr_cnt - wr0); end
        while (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            got  = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
            checks++; if (got !== want) begin errors++; $display("FAIL b2b_byte got %h want %h", got, want); end
        end
    endtask

    task automatic test_reset_mid_frame;
        int wr0;
        logic [7:0] d;
        wr0 = wr_cnt;
        d = 8'h81;
        rx = 1'b0;
        idle(BIT);
        for (int i = 0; i < 4; i++) begin
            rx = d[i];
            idle(BIT);
        end
        rx = d[4];
        idle(200);
        rst_n = 1'b0;
        rx    = 1'b1;
        idle(4);
        rst_n = 1'b1;
        idle(2);
        checks++; if (state_dbg !== S_IDLE) begin errors++; $display("FAIL midrst_state got %0d want %0d", state_dbg, S_IDLE); end
        checks++; if (dout !== 8'h00) begin errors++; $display("FAIL midrst_dout got %h want 00", dout); end
        idle(BIT * 8);
        checks++; if (wr_cnt - wr0 !== 0) begin errors++; $display("FAIL midrst_no_write got %0d want 0", wr_cnt - wr0); end
        send_frame(8'h7E, 1'b1, 1'b0, 1'b0);
        idle(50);
        checks++; if (wr_cnt - wr0 !== 1) begin errors++; $display("FAIL midrst_next_wr got %0d want 1", wr_cnt - wr0); end
        checks++; if (dout !== 8'h7E) begin errors++; $display("FAIL midrst_next_dout got %h want 7e", dout); end
    endtask

    initial begin
        rst_n = 1'b0;
        rx    = 1'b1;
        full  = 1'b0;
        test_reset();
        test_basic();
        test_glitch();
        test_frame_err();
        test_overrun();
        test_full_ignored();
        test_back_to_back();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLK_HZ, default 50000000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200, line bit rate.
REQ-003 Parameter BIT_DIV, default CLK_HZ/BAUD (434), clock cycles per bit.
REQ-004 Port clk_50mhz, input, 1, the single clock for all logic.
REQ-005 Port rst_n, input, 1, synchronous active-low reset.
REQ-006 Port rx, input, 1, asynchronous RS232 serial line, idle high.
REQ-007 Port wr_clk, output, 1, FIFO write clock.
REQ-008 Port wr_en, output, 1, FIFO write strobe.
REQ-009 Port dout, output, 8, received byte to the FIFO.
REQ-010 Port full, input, 1, FIFO full flag.
REQ-011 Port frame_err, output, 1, one-cycle pulse on a bad stop bit.
REQ-012 Port overrun, output, 1, one-cycle pulse when a good byte is dropped because full=1.

Function
REQ-013 Frame format SHALL be 8N1: one start bit (0), 8 data bits LSB first, one stop bit (1), no parity.
REQ-014 rx SHALL pass through a 2-flop synchronizer; only the synchronized value (rx_s) SHALL be used.
REQ-015 wr_clk SHALL be driven directly from clk_50mhz.
REQ-016 The state machine SHALL have the states IDLE, START, DATA, STOP and WAIT_HIGH.
REQ-017 IDLE: a 1->0 transition of rx_s SHALL enter START and clear the bit counter (9-bit, sized for BIT_DIV up to 511).
REQ-018 START: after BIT_DIV/2 cycles, rx_s SHALL be sampled; 1 = false start, return to IDLE with no outputs asserted; 0 = enter DATA with the counter cleared.
REQ-019 DATA: every BIT_DIV cycles, rx_s SHALL be sampled and shifted in LSB first; after the 8th sample, enter STOP.
REQ-020 STOP: after BIT_DIV cycles, rx_s SHALL be sampled, and the FSM SHALL go to IDLE if the sample is 1 or to WAIT_HIGH if it is 0.
REQ-021 Stop sample 1 with full=0: wr_en SHALL be high for exactly one cycle, on the cycle after the stop sample, with dout holding the byte.
REQ-022 Stop sample 1 with full=1: the byte SHALL be dropped, wr_en SHALL stay 0, and overrun SHALL pulse for one cycle at the time wr_en would have pulsed.
REQ-023 Stop sample 0: frame_err SHALL pulse for one cycle, no write SHALL occur, and the FSM SHALL stay in WAIT_HIGH until rx_s = 1, then go to IDLE (break tolerance).
REQ-024 full SHALL be evaluated only in the stop-sample cycle; changes on full at other times SHALL have no effect.
REQ-025 dout SHALL hold the last written byte until the next write.
REQ-026 A start edge arriving in the cycle the FSM returns to IDLE SHALL be detected, so back-to-back frames with one stop bit are received without loss.

Reset
REQ-027 When rst_n = 0 at a clock edge, the FSM SHALL go to IDLE and the counters and shift register SHALL clear.
REQ-028 Reset values SHALL be: wr_en=0, frame_err=0, overrun=0, dout=8'h00, synchronizer flops = 1.
REQ-029 Reset mid-frame SHALL abandon the frame with no write, and the first full frame after reset release SHALL be received normally.

Structure
REQ-030 BIT_DIV, the state encodings and the 8N1 frame constants SHALL live in the shared UART definitions header, which the transmit side also uses.
REQ-031 Bit timing SHALL be one sub-module, rx_bit_timer: it is cleared on start detect and issues a one-cycle sample tick at BIT_DIV/2 and then every BIT_DIV cycles.
REQ-032 The sub-module rs232_rx SHALL contain the synchronizer, FSM, shift register and FIFO interface; uart_rx SHALL instantiate rs232_rx and rx_bit_timer.

Verification
REQ-033 Drive 0x55 at 434 cycles/bit with full=0 -> exactly one wr_en pulse, with dout=8'h55.
REQ-034 Drive a 100-cycle low glitch on idle rx -> no wr_en, no frame_err, and the FSM back in IDLE.
REQ-035 Drive 0xA3 with stop bit 0, rx held low a further 2000 cycles -> one frame_err pulse, no wr_en; a following 0x3C is received correctly only after rx returns high.
REQ-036 Drive 0xA3 with full=1 -> one overrun pulse, no wr_en, dout unchanged.
REQ-037 Drive 0x00 then 0xFF back-to-back with one stop bit -> two wr_en pulses, 0x00 then 0xFF.
REQ-038 Assert rst_n=0 during data bit 4 of 0x81 -> no write; the next 0x7E -> written as 0x7E.
